fwd_hazard_unit: RTL



---
 rtl/fwd_hazard_unit_pkg.sv | 27 ++
 rtl/fwd_hazard_unit_if.sv | 29 ++
 rtl/fwd_src_resolve.sv | 28 ++
 rtl/fwd_hazard_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared types and parameter checks for the forwarding/hazard unit
package fwd_pkg;

    // Tag entries carry rd at a fixed maximum width so the struct can live here;
    // narrower register files are zero-extended on the way in.
    localparam int MAX_REG_AW = 8;

    // Select value meaning "take the operand from the register file".
    localparam int SEL_REGFILE = 0;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  is_load;
        logic [MAX_REG_AW-1:0] rd;
    } tag_entry_t;

    localparam tag_entry_t TAG_BUBBLE = '0;

    // Load data must become forwardable before it falls off the end of the tag
    // pipeline, and at least one older slot beyond EX must exist to be stored.
    function automatic bit fwd_params_legal(input int reg_aw, input int depth, input int load_lat);
        return (reg_aw >= 1) && (reg_aw <= MAX_REG_AW) &&
               (depth >= 2) && (load_lat >= 0) && (load_lat < depth);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - ID-stage issue / EX-select bundle for the forwarding unit
interface fwd_hazard_unit_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int SELW    = $clog2(DEPTH + 1)
);
    logic                      issue_valid;
    logic                      issue_we;
    logic                      issue_is_load;
    logic [REG_AW-1:0]         issue_rd;
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic                      flush;
    logic                      stall;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;
    logic [15:0]               stall_cnt;

    // Pipeline control side: presents the ID instruction, consumes stall and selects.
    modport master (
        output issue_valid, issue_we, issue_is_load, issue_rd, id_rs, flush,
        input  stall, fwd_sel, stall_cnt
    );

    // Hazard unit side.
    modport slave (
        input  issue_valid, issue_we, issue_is_load, issue_rd, id_rs, flush,
        output stall, fwd_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_src_resolve.sv
// rtl/fwd_src_resolve.sv - priority comparator picking the youngest producer of one source
module fwd_src_resolve
    import fwd_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = $clog2(DEPTH + 1)
) (
    input  logic [MAX_REG_AW-1:0] rs,
    input  tag_entry_t            cand [DEPTH],
    output logic [SELW-1:0]       sel,
    output logic                  load_hazard
);

    // cand[k] lands in slot k+1 next cycle; scanning oldest to youngest lets the
    // youngest match overwrite older ones. Register 0 never matches.
    always_comb begin
        sel         = SELW'(SEL_REGFILE);
        load_hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if ((rs != '0) && cand[k].valid && cand[k].we && (cand[k].rd == rs)) begin
                sel         = SELW'(k + 1);
                load_hazard = cand[k].is_load && ((k + 1) <= LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load-use stall generation
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_unit_if.slave  bus
);

    if (!fwd_params_legal(REG_AW, DEPTH, LOAD_LAT)) begin : g_bad_params
        $error("fwd_hazard_unit: illegal REG_AW/DEPTH/LOAD_LAT combination");
    end

    // The entry leaving slot[DEPTH-1] becomes slot[DEPTH], which is never a
    // forwarding candidate (it would be slot DEPTH+1 by the time the consumer
    // reaches EX), so only slots 1..DEPTH-1 are actually stored.
    tag_entry_t ex_entry;
    tag_entry_t slot [1:DEPTH-1];
    tag_entry_t cand [DEPTH];
    tag_entry_t id_entry;

    logic [SELW-1:0]         src_sel [NUM_SRC];
    logic [NUM_SRC-1:0]      src_hz;
    logic [NUM_SRC*SELW-1:0] sel_packed;
    logic                    stall_int;
    logic                    advance;
    logic [NUM_SRC*SELW-1:0] fwd_sel_q;
    logic [15:0]             stall_cnt_q;

    // Candidate list in youngest-first order: EX, then the stored older slots.
    always_comb begin
        cand[0] = ex_entry;
        for (int k = 1; k < DEPTH; k++) begin
            cand[k] = slot[k];
        end
    end

    // Tag for the ID instruction, should it be allowed into EX this cycle.
    always_comb begin
        id_entry         = TAG_BUBBLE;
        id_entry.valid   = bus.issue_valid;
        id_entry.we      = bus.issue_we;
        id_entry.is_load = bus.issue_is_load;
        id_entry.rd      = MAX_REG_AW'(bus.issue_rd);
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [MAX_REG_AW-1:0] rs_ext;
        assign rs_ext = MAX_REG_AW'(bus.id_rs[s*REG_AW +: REG_AW]);

        fwd_src_resolve #(
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SELW     (SELW)
        ) u_resolve (
            .rs          (rs_ext),
            .cand        (cand),
            .sel         (src_sel[s]),
            .load_hazard (src_hz[s])
        );
    end

    // Pack per-source selects, src0 in the LSBs.
    always_comb begin
        sel_packed = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            sel_packed[s*SELW +: SELW] = src_sel[s];
        end
    end

    assign stall_int = bus.issue_valid && (|src_hz);
    assign advance   = bus.issue_valid && !stall_int && !bus.flush;

    // Tag pipeline: slots shift every cycle regardless of stall; EX takes the ID
    // instruction only when it advances, otherwise a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_entry <= TAG_BUBBLE;
            for (int k = 1; k < DEPTH; k++) begin
                slot[k] <= TAG_BUBBLE;
            end
        end else begin
            slot[1] <= ex_entry;
            for (int k = 2; k < DEPTH; k++) begin
                slot[k] <= slot[k-1];
            end
            ex_entry <= advance ? id_entry : TAG_BUBBLE;
        end
    end

    // EX operand mux selects follow the instruction into EX; bubbles read the regfile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_sel_q <= '0;
        end else begin
            fwd_sel_q <= advance ? sel_packed : '0;
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_int && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall     = stall_int;
    assign bus.fwd_sel   = fwd_sel_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule
